// File: rtl/operand_streamer_pkg.sv
// Shared types and defaults for the operand streamer and its FIFOs.
package operand_streamer_pkg;

  localparam int unsigned FifoDepthDefault = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitRun,
    StStream,
    StWaitEnd,
    StDone
  } state_e;

endpackage

// File: rtl/operand_streamer_if.sv
// Operand channels and start/running handshake between streamer and accelerator.
interface operand_streamer_if #(
  parameter int unsigned IO_DATA_WIDTH = 16
) ();

  logic [IO_DATA_WIDTH-1:0] a_input;
  logic [IO_DATA_WIDTH-1:0] b_input;
  logic                     a_valid;
  logic                     b_valid;
  logic                     a_ready;
  logic                     b_ready;
  logic                     start;
  logic                     running;

  modport master (
    output a_input, b_input, a_valid, b_valid, start,
    input  a_ready, b_ready, running
  );

  modport slave (
    input  a_input, b_input, a_valid, b_valid, start,
    output a_ready, b_ready, running
  );

endinterface

// File: rtl/operand_fifo.sv
// Single-clock FIFO with head-of-queue output (zero when empty) and drop-on-full push.
module operand_fifo
  import operand_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = FifoDepthDefault
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic                  dropped
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         count_q;
  logic                  wr_en, rd_en;

  // Fullness is judged on the registered count, so a pop in the same cycle never rescues a push.
  assign full    = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;
  assign dropped = push && full;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/operand_streamer.sv
// Buffers host operands and streams a configured number of words per channel to an accelerator.
module operand_streamer
  import operand_streamer_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH    = FifoDepthDefault,
  parameter int unsigned COUNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic [IO_DATA_WIDTH-1:0] host_a_data,
  input  logic [IO_DATA_WIDTH-1:0] host_b_data,
  input  logic                     host_a_push,
  input  logic                     host_b_push,
  output logic                     host_a_full,
  output logic                     host_b_full,
  output logic                     overflow,
  input  logic [COUNT_WIDTH-1:0]   cfg_a_count,
  input  logic [COUNT_WIDTH-1:0]   cfg_b_count,
  input  logic                     go,
  output logic                     busy,
  output logic                     done,
  operand_streamer_if.master       acc
);

  state_e                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   a_rem_q, b_rem_q;
  logic                     overflow_q;
  logic [IO_DATA_WIDTH-1:0] a_head, b_head;
  logic                     a_empty, b_empty, a_drop, b_drop;
  logic                     a_valid, b_valid, a_xfer, b_xfer;
  logic                     start_s, done_s;

  operand_fifo #(.DATA_WIDTH(IO_DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk     (clk),
    .clear   (rst_in),
    .wdata   (host_a_data),
    .push    (host_a_push),
    .pop     (a_xfer),
    .head    (a_head),
    .full    (host_a_full),
    .empty   (a_empty),
    .dropped (a_drop)
  );

  operand_fifo #(.DATA_WIDTH(IO_DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk     (clk),
    .clear   (rst_in),
    .wdata   (host_b_data),
    .push    (host_b_push),
    .pop     (b_xfer),
    .head    (b_head),
    .full    (host_b_full),
    .empty   (b_empty),
    .dropped (b_drop)
  );

  // Valid derives only from registered state, so it cannot depend on ready.
  assign a_valid = (state_q == StStream) && !a_empty && (a_rem_q != '0);
  assign b_valid = (state_q == StStream) && !b_empty && (b_rem_q != '0);
  assign a_xfer  = a_valid && acc.a_ready;
  assign b_xfer  = b_valid && acc.b_ready;

  assign acc.a_valid = a_valid;
  assign acc.b_valid = b_valid;
  assign acc.a_input = a_head;
  assign acc.b_input = b_head;
  assign acc.start   = start_s;
  assign busy        = (state_q != StIdle);
  assign done        = done_s;
  assign overflow    = overflow_q;

  always_comb begin
    state_d = state_q;
    start_s = 1'b0;
    done_s  = 1'b0;
    unique case (state_q)
      StIdle:    if (go) state_d = StStart;
      StStart: begin
        start_s = 1'b1;
        state_d = StWaitRun;
      end
      StWaitRun: if (acc.running) state_d = StStream;
      StStream:  if ((a_rem_q == '0) && (b_rem_q == '0)) state_d = StWaitEnd;
      StWaitEnd: if (!acc.running) state_d = StDone;
      StDone: begin
        done_s  = 1'b1;
        state_d = StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q    <= StIdle;
      a_rem_q    <= '0;
      b_rem_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_q | a_drop | b_drop;
      if ((state_q == StIdle) && go) begin
        a_rem_q <= cfg_a_count;
        b_rem_q <= cfg_b_count;
      end else begin
        if (a_xfer) a_rem_q <= a_rem_q - 1'b1;
        if (b_xfer) b_rem_q <= b_rem_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_streamer.sv
// Directed bench for operand_streamer: ordered streaming, backpressure, overflow, reset and idle rules.
module tb_operand_streamer;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [15:0] host_a_data, host_b_data;
  logic        host_a_push, host_b_push;
  logic        host_a_full, host_b_full, overflow;
  logic [31:0] cfg_a_count, cfg_b_count;
  logic        go, busy, done;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_a[$], exp_b[$], got_a[$], got_b[$];

  operand_streamer_if #(.IO_DATA_WIDTH(16)) acc_if ();

  operand_streamer dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .host_a_data (host_a_data),
    .host_b_data (host_b_data),
    .host_a_push (host_a_push),
    .host_b_push (host_b_push),
    .host_a_full (host_a_full),
    .host_b_full (host_b_full),
    .overflow    (overflow),
    .cfg_a_count (cfg_a_count),
    .cfg_b_count (cfg_b_count),
    .go          (go),
    .busy        (busy),
    .done        (done),
    .acc         (acc_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_a_valid"}, 32'(acc_if.a_valid), 0);
    check({tag, "_b_valid"}, 32'(acc_if.b_valid), 0);
    check({tag, "_start"}, 32'(acc_if.start), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_a_full"}, 32'(host_a_full), 0);
    check({tag, "_b_full"}, 32'(host_b_full), 0);
    check({tag, "_a_input"}, 32'(acc_if.a_input), 0);
    check({tag, "_b_input"}, 32'(acc_if.b_input), 0);
  endtask

  task automatic push_words(input logic [15:0] a, input logic pa, input logic [15:0] b,
                            input logic pb);
    host_a_data = a;
    host_b_data = b;
    host_a_push = pa;
    host_b_push = pb;
    tick();
    host_a_push = 1'b0;
    host_b_push = 1'b0;
  endtask

  // mode 0: both readies high; mode 1: a_ready toggles, b_ready low for the first 5 stream cycles
  task automatic run_stream(input int unsigned ca, input int unsigned cb, input int mode);
    logic        a_pend, b_pend, finished, start_extra;
    logic [15:0] a_prev, b_prev;
    a_pend = 1'b0; b_pend = 1'b0; finished = 1'b0; start_extra = 1'b0;
    a_prev = '0; b_prev = '0;
    got_a.delete();
    got_b.delete();
    cfg_a_count = ca;
    cfg_b_count = cb;
    go = 1'b1;
    tick();
    go = 1'b0;
    check("start_pulse", 32'(acc_if.start), 1);
    check("busy_run", 32'(busy), 1);
    tick();
    check("start_once", 32'(acc_if.start), 0);
    acc_if.running = 1'b1;
    for (int c = 0; c < 60; c++) begin
      acc_if.a_ready = (mode == 0) ? 1'b1 : c[0];
      acc_if.b_ready = (mode == 0) ? 1'b1 : (c >= 6);
      if (a_pend) begin
        check("a_hold_valid", 32'(acc_if.a_valid), 1);
        check("a_hold_data", 32'(acc_if.a_input), 32'(a_prev));
      end
      if (b_pend) begin
        check("b_hold_valid", 32'(acc_if.b_valid), 1);
        check("b_hold_data", 32'(acc_if.b_input), 32'(b_prev));
      end
      if (acc_if.start) start_extra = 1'b1;
      if (acc_if.a_valid && acc_if.a_ready) got_a.push_back(acc_if.a_input);
      if (acc_if.b_valid && acc_if.b_ready) got_b.push_back(acc_if.b_input);
      a_pend = acc_if.a_valid && !acc_if.a_ready;
      b_pend = acc_if.b_valid && !acc_if.b_ready;
      a_prev = acc_if.a_input;
      b_prev = acc_if.b_input;
      if (c >= 3 && got_a.size() == ca && got_b.size() == cb &&
          !acc_if.a_valid && !acc_if.b_valid) begin
        finished = 1'b1;
        break;
      end
      tick();
    end
    acc_if.a_ready = 1'b0;
    acc_if.b_ready = 1'b0;
    check("stream_finished", 32'(finished), 1);
    check("no_restart", 32'(start_extra), 0);
    check("a_count_sent", got_a.size(), exp_a.size());
    check("b_count_sent", got_b.size(), exp_b.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      check("a_order", 32'(got_a[i]), 32'(exp_a[i]));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      check("b_order", 32'(got_b[i]), 32'(exp_b[i]));
    tick();
    tick();
    check("busy_wait_end", 32'(busy), 1);
    check("no_early_done", 32'(done), 0);
    acc_if.running = 1'b0;
    tick();
    check("done_pulse", 32'(done), 1);
    tick();
    check("done_one_cycle", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
  endtask

  initial begin
    rst_in = 1'b1;
    host_a_data = '0; host_b_data = '0; host_a_push = 1'b0; host_b_push = 1'b0;
    cfg_a_count = '0; cfg_b_count = '0; go = 1'b0;
    acc_if.a_ready = 1'b0; acc_if.b_ready = 1'b0; acc_if.running = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    check_idle_outputs("reset");

    // In-order streaming with ready always high
    push_words(16'd1, 1'b1, 16'd4, 1'b1);
    push_words(16'd2, 1'b1, 16'd5, 1'b1);
    push_words(16'd3, 1'b1, 16'd6, 1'b1);
    check("head_a_idle", 32'(acc_if.a_input), 1);
    check("head_b_idle", 32'(acc_if.b_input), 4);
    check("no_valid_idle", 32'(acc_if.a_valid), 0);
    exp_a = '{16'd1, 16'd2, 16'd3};
    exp_b = '{16'd4, 16'd5, 16'd6};
    run_stream(3, 3, 0);

    // Backpressure: counts 4/2
    push_words(16'd10, 1'b1, 16'd20, 1'b1);
    push_words(16'd11, 1'b1, 16'd21, 1'b1);
    push_words(16'd12, 1'b1, 16'd0, 1'b0);
    push_words(16'd13, 1'b1, 16'd0, 1'b0);
    exp_a = '{16'd10, 16'd11, 16'd12, 16'd13};
    exp_b = '{16'd20, 16'd21};
    run_stream(4, 2, 1);
    check("empty_a_after", 32'(acc_if.a_input), 0);

    // Zero counts: full walk through the FSM, leftover word kept
    push_words(16'h77, 1'b1, 16'd0, 1'b0);
    exp_a.delete();
    exp_b.delete();
    run_stream(0, 0, 0);
    check("leftover_kept", 32'(acc_if.a_input), 32'h77);

    // go during STREAM plus simultaneous push/pop at occupancy 4
    push_words(16'h78, 1'b1, 16'd0, 1'b0);
    push_words(16'h79, 1'b1, 16'd0, 1'b0);
    push_words(16'h7a, 1'b1, 16'd0, 1'b0);
    cfg_a_count = 32'd1;
    cfg_b_count = 32'd0;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    acc_if.running = 1'b1;
    tick();
    check("stream_a_valid", 32'(acc_if.a_valid), 1);
    check("stream_a_head", 32'(acc_if.a_input), 32'h77);
    host_a_data = 16'h7b;
    host_a_push = 1'b1;
    acc_if.a_ready = 1'b1;
    go = 1'b1;
    tick();
    host_a_push = 1'b0;
    acc_if.a_ready = 1'b0;
    go = 1'b0;
    check("popped_head", 32'(acc_if.a_input), 32'h78);
    check("count_exhausted", 32'(acc_if.a_valid), 0);
    check("go_no_start", 32'(acc_if.start), 0);
    tick();
    acc_if.running = 1'b0;
    tick();
    check("go_ignored_done", 32'(done), 1);
    tick();
    check("go_ignored_idle", 32'(busy), 0);
    check("go_ignored_start", 32'(acc_if.start), 0);
    push_words(16'h7c, 1'b1, 16'd0, 1'b0);
    push_words(16'h7d, 1'b1, 16'd0, 1'b0);
    push_words(16'h7e, 1'b1, 16'd0, 1'b0);
    check("occ7_not_full", 32'(host_a_full), 0);
    push_words(16'h7f, 1'b1, 16'd0, 1'b0);
    check("occ8_full", 32'(host_a_full), 1);

    // Overflow on a fresh FIFO: nine pushes
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_idle_outputs("reset2");
    for (int i = 1; i <= 7; i++) push_words(16'(i), 1'b1, 16'd0, 1'b0);
    check("full_after7", 32'(host_a_full), 0);
    push_words(16'd8, 1'b1, 16'd0, 1'b0);
    check("full_after8", 32'(host_a_full), 1);
    check("no_ovf_after8", 32'(overflow), 0);
    push_words(16'd9, 1'b1, 16'd0, 1'b0);
    check("ovf_after9", 32'(overflow), 1);
    check("full_after9", 32'(host_a_full), 1);
    tick();
    tick();
    check("ovf_sticky", 32'(overflow), 1);
    check("head_after_ovf", 32'(acc_if.a_input), 1);

    // Reset mid-STREAM after two of five transfers
    cfg_a_count = 32'd5;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    acc_if.running = 1'b1;
    acc_if.a_ready = 1'b1;
    tick();
    check("mid_first", 32'(acc_if.a_input), 1);
    tick();
    check("mid_second", 32'(acc_if.a_input), 2);
    tick();
    check("mid_third_valid", 32'(acc_if.a_valid), 1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    acc_if.running = 1'b0;
    acc_if.a_ready = 1'b0;
    check_idle_outputs("mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_streamer.md
OPERAND_STREAMER -- requirements
Module: operand_streamer

Interface
REQ-001 SHALL have parameter IO_DATA_WIDTH, default 16, operand word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per operand FIFO, power of two, minimum 2.
REQ-003 SHALL have parameter COUNT_WIDTH, default 32, width of transfer counters.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_in  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports host_a_data/host_b_data  in  IO_DATA_WIDTH  host words to enqueue.
REQ-007 SHALL have ports host_a_push/host_b_push  in  1  enqueue strobes.
REQ-008 SHALL have ports host_a_full/host_b_full  out  1  FIFO full.
REQ-009 SHALL have port overflow  out  1  sticky flag, set by a push while full.
REQ-010 SHALL have ports cfg_a_count/cfg_b_count  in  COUNT_WIDTH  words to send per run.
REQ-011 SHALL have ports go (in 1, run request pulse), busy (out 1), done (out 1, one-cycle completion pulse).
REQ-012 SHALL have ports a_input/b_input  out  IO_DATA_WIDTH, a_valid/b_valid  out  1, a_ready/b_ready  in  1: operand channels to the accelerator.
REQ-013 SHALL have ports start  out  1 (accelerator start pulse) and running  in  1 (accelerator busy).

Function
REQ-014 SHALL contain one FIFO per channel; a push when not full is written, becomes visible at the head the following cycle; a push when full is dropped and sets overflow, even if a pop occurs in the same cycle.
REQ-015 SHALL support a simultaneous push and pop on a non-full, non-empty FIFO with occupancy unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-016 SHALL implement FSM states IDLE, START, WAIT_RUN, STREAM, WAIT_END, DONE.
REQ-017 IDLE: on go, SHALL latch cfg_a_count/cfg_b_count into remaining counters and move to START; busy=0.
REQ-018 START: SHALL drive start=1 for exactly one cycle, then move to WAIT_RUN.
REQ-019 WAIT_RUN: SHALL wait for running=1, then move to STREAM.
REQ-020 STREAM: a_valid SHALL equal (A FIFO non-empty AND a_remaining!=0); the B channel likewise and independently.
REQ-021 A transfer SHALL occur when valid and ready are both high; it pops the FIFO and decrements the remaining count in the same cycle.
REQ-022 Once valid is high, a_input/a_valid (and b_input/b_valid) SHALL stay stable until the transfer; valid SHALL NOT depend combinationally on ready.
REQ-023 When both remaining counts are 0, SHALL move to WAIT_END, with no valid asserted.
REQ-024 WAIT_END: SHALL wait for running=0, then move to DONE.
REQ-025 DONE: SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE; go outside IDLE SHALL be ignored.
REQ-027 With both counts 0, the FSM SHALL still go through START, WAIT_RUN, STREAM (one cycle, no transfers), WAIT_END and DONE.
REQ-028 Outside STREAM, a_valid and b_valid SHALL be 0; a_input and b_input SHALL show the FIFO head, or 0 when the FIFO is empty.
REQ-029 Words left in the FIFOs after a run SHALL be kept for the next run.

Reset
REQ-030 While rst_in is high at a clock edge, the block SHALL clear the FIFOs and counters, clear overflow, and enter IDLE; this applies mid-run too.
REQ-031 After reset, SHALL drive these outputs: a_valid=b_valid=start=busy=done=overflow=0, host_a_full=host_b_full=0, a_input=b_input=0.

Structure
REQ-032 The FSM state enum and FIFO_DEPTH default SHALL live in the shared package.
REQ-033 The FIFO SHALL be one sub-module, operand_fifo, instantiated twice.

Verification
REQ-034 Push A=1,2,3 and B=4,5,6, counts 3/3, go, ready always high -> start pulses once; after running=1, A sends 1,2,3 and B sends 4,5,6 in order; done pulses one cycle after running falls.
REQ-035 Counts 4/2 with a_ready toggling every cycle and b_ready held low for 5 cycles -> no word is lost or duplicated; data stays stable while valid is high and ready is low.
REQ-036 Push 9 words into A with FIFO_DEPTH=8 -> host_a_full=1 after 8; the 9th is dropped; overflow=1 until reset.
REQ-037 Counts 0/0, go -> start pulse, no valid ever asserted, done after running falls.
REQ-038 Assert rst_in mid-STREAM after 2 of 5 transfers -> next cycle IDLE, FIFOs empty, all outputs 0.
REQ-039 go during STREAM, and push plus pop in the same cycle at occupancy 4 -> go is ignored; occupancy stays 4.
